// File: rtl/npu_pkg.sv
// npu_pkg: definitions shared by the host driver and the NPU.
//   - npu_state_t : host driver FSM states
//   - header field positions and widths, packed header struct
//   - ZERO_HIDDEN / ONE_HIDDEN / TWO_HIDDEN : num_layers encodings
package npu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LOAD,
        INPUT,
        WAIT,
        READ,
        DONE
    } npu_state_t;

    // Header word layout: [1:0] num_layers, then four 5-bit neuron fields.
    localparam int HDR_NL_LSB = 0;
    localparam int HDR_NL_W   = 2;
    localparam int HDR_N0_LSB = 2;
    localparam int HDR_N1_LSB = 7;
    localparam int HDR_N2_LSB = 12;
    localparam int HDR_N3_LSB = 17;
    localparam int HDR_N_W    = 5;
    localparam int HDR_W      = 22;

    localparam logic [1:0] ZERO_HIDDEN = 2'd0;
    localparam logic [1:0] ONE_HIDDEN  = 2'd1;
    localparam logic [1:0] TWO_HIDDEN  = 2'd2;
    localparam logic [1:0] BAD_LAYERS  = 2'd3;

    localparam logic [2:0] CFG_LAST = 3'd4;  // five config words: 0..4

    // Member order mirrors the bit positions above (first member is MSB).
    typedef struct packed {
        logic [HDR_N_W-1:0]  n3;
        logic [HDR_N_W-1:0]  n2;
        logic [HDR_N_W-1:0]  n1;
        logic [HDR_N_W-1:0]  n0;
        logic [HDR_NL_W-1:0] num_layers;
    } npu_hdr_t;

    function automatic npu_hdr_t unpack_hdr(input logic [31:0] w);
        return npu_hdr_t'(w[HDR_W-1:0]);
    endfunction

endpackage

// File: rtl/npu_layer_seq.sv
// npu_layer_seq: walks the LOAD phase of a job.
//   clk, rst   : clock, synchronous active-high reset
//   hdr        : latched header (npu_hdr_t bits)
//   start      : hold counters at zero (asserted whenever not in LOAD)
//   advance    : one LOAD word was passed to the NPU this cycle
//   fanin      : current layer fan-in field (count - 1)
//   neurons    : current layer neuron field (count - 1)
//   last_word  : the current word is the final bias of the final layer
module npu_layer_seq
    import npu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [HDR_W-1:0] hdr,
    input  logic             start,
    input  logic             advance,
    output logic [4:0]       fanin,
    output logic [4:0]       neurons,
    output logic             last_word
);

    npu_hdr_t h;
    logic [5:0] w_cnt;      // 0..fanin_count: weights then bias
    logic [4:0] neu_cnt;
    logic [1:0] layer_idx;
    logic       last_w, last_neu, last_layer;

    assign h = npu_hdr_t'(hdr);

    // The output layer is always n3; hidden layers chain n0 -> n1 -> n2.
    always_comb begin
        fanin   = h.n0;
        neurons = h.n3;
        case (layer_idx)
            2'd0: begin
                fanin   = h.n0;
                neurons = (h.num_layers == ZERO_HIDDEN) ? h.n3 : h.n1;
            end
            2'd1: begin
                fanin   = h.n1;
                neurons = (h.num_layers == ONE_HIDDEN) ? h.n3 : h.n2;
            end
            default: begin
                fanin   = h.n2;
                neurons = h.n3;
            end
        endcase
    end

    // A neuron carries fanin+1 weights plus one bias, so w_cnt ends at fanin+1.
    assign last_w     = (w_cnt == ({1'b0, fanin} + 6'd1));
    assign last_neu   = (neu_cnt == neurons);
    assign last_layer = (layer_idx == h.num_layers);
    assign last_word  = last_w & last_neu & last_layer;

    always_ff @(posedge clk) begin
        if (rst || start) begin
            w_cnt     <= '0;
            neu_cnt   <= '0;
            layer_idx <= '0;
        end else if (advance) begin
            if (!last_w) begin
                w_cnt <= w_cnt + 6'd1;
            end else begin
                w_cnt <= '0;
                if (!last_neu) begin
                    neu_cnt <= neu_cnt + 5'd1;
                end else begin
                    neu_cnt   <= '0;
                    layer_idx <= layer_idx + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/npu_host_driver.sv
// npu_host_driver: plays one job from a word stream onto the NPU bus and
// returns the output neurons on a valid/ready stream.
//   clk, rst                     : clock, synchronous active-high reset
//   src_valid/src_data/src_ready : job word stream in
//   npu_we, npu_data_out         : bus word strobe and data toward the NPU
//   npu_data_oe                  : tristate enable, same as npu_we
//   npu_data_in, npu_oe          : read-back data and read strobe
//   npu_ready                    : NPU holds results
//   dst_valid/dst_data/dst_ready : output neuron stream
//   busy, done, err              : status (err is sticky)
module npu_host_driver
    import npu_pkg::*;
#(
    parameter logic [15:0] READY_TIMEOUT = 16'd4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    output logic        npu_we,
    output logic [31:0] npu_data_out,
    output logic        npu_data_oe,
    input  logic [31:0] npu_data_in,
    output logic        npu_oe,
    input  logic        npu_ready,
    output logic        dst_valid,
    output logic [31:0] dst_data,
    input  logic        dst_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    npu_state_t state, state_nxt;
    npu_hdr_t   hdr;

    logic [2:0]  cfg_cnt;
    logic [4:0]  in_cnt;
    logic [15:0] wait_cnt;
    logic [5:0]  rd_cnt;

    logic       hdr_take, hdr_bad, underrun, timeout;
    logic       seq_last;
    logic [4:0] seq_fanin, seq_neurons;

    npu_layer_seq u_seq (
        .clk       (clk),
        .rst       (rst),
        .hdr       (hdr),
        .start     (state != LOAD),
        .advance   ((state == LOAD) && src_valid),
        .fanin     (seq_fanin),
        .neurons   (seq_neurons),
        .last_word (seq_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        src_ready    = 1'b0;
        npu_we       = 1'b0;
        npu_data_out = '0;
        npu_oe       = 1'b0;
        hdr_take     = 1'b0;
        hdr_bad      = 1'b0;
        underrun     = 1'b0;
        timeout      = 1'b0;
        case (state)
            IDLE: begin
                src_ready = 1'b1;
                if (src_valid) begin
                    if (src_data[HDR_NL_LSB +: HDR_NL_W] == BAD_LAYERS) begin
                        hdr_bad = 1'b1;
                    end else begin
                        hdr_take  = 1'b1;
                        state_nxt = CFG;
                    end
                end
            end
            CFG: begin
                npu_we = 1'b1;
                case (cfg_cnt)
                    3'd0:    npu_data_out = {30'b0, hdr.num_layers};
                    3'd1:    npu_data_out = {27'b0, hdr.n0};
                    3'd2:    npu_data_out = {27'b0, hdr.n1};
                    3'd3:    npu_data_out = {27'b0, hdr.n2};
                    default: npu_data_out = {27'b0, hdr.n3};
                endcase
                if (cfg_cnt == CFG_LAST) state_nxt = LOAD;
            end
            LOAD, INPUT: begin
                // Unregistered passthrough: the source word is on the bus
                // in the same cycle it is consumed.
                src_ready    = 1'b1;
                npu_we       = src_valid;
                npu_data_out = src_data;
                if (!src_valid) begin
                    underrun  = 1'b1;
                    state_nxt = IDLE;
                end else if (state == LOAD && seq_last) begin
                    state_nxt = INPUT;
                end else if (state == INPUT && in_cnt == hdr.n0) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (npu_ready) begin
                    state_nxt = READ;
                end else if (wait_cnt == READY_TIMEOUT - 16'd1) begin
                    timeout   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            READ: begin
                // Read only when the holding register is free or emptying.
                npu_oe = npu_ready && (!dst_valid || dst_ready) &&
                         (rd_cnt <= {1'b0, hdr.n3});
                if ((rd_cnt == {1'b0, hdr.n3} + 6'd1) && dst_valid && dst_ready)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr       <= '0;
            err       <= 1'b0;
            cfg_cnt   <= '0;
            in_cnt    <= '0;
            wait_cnt  <= '0;
            rd_cnt    <= '0;
            dst_valid <= 1'b0;
            dst_data  <= '0;
        end else begin
            if (hdr_take) begin
                hdr <= unpack_hdr(src_data);
                err <= 1'b0;
            end else if (hdr_bad || underrun || timeout) begin
                err <= 1'b1;
            end

            cfg_cnt  <= (state == CFG) ? cfg_cnt + 3'd1 : 3'd0;
            in_cnt   <= (state == INPUT && src_valid) ? in_cnt + 5'd1 : 5'd0;
            wait_cnt <= (state == WAIT) ? wait_cnt + 16'd1 : 16'd0;

            if (state != READ) rd_cnt <= '0;
            else if (npu_oe)   rd_cnt <= rd_cnt + 6'd1;

            // Capture wins over acceptance, so a word is replaced with no bubble.
            if (npu_oe) begin
                dst_data  <= npu_data_in;
                dst_valid <= 1'b1;
            end else if (dst_ready) begin
                dst_valid <= 1'b0;
            end
        end
    end

    assign npu_data_oe = npu_we;
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_npu_host_driver.sv
module tb_npu_host_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_valid = 1'b0;
    logic [31:0] src_data = '0;
    logic        src_ready;
    logic        npu_we;
    logic [31:0] npu_data_out;
    logic        npu_data_oe;
    logic [31:0] npu_data_in;
    logic        npu_oe;
    logic        npu_ready = 1'b0;
    logic        dst_valid;
    logic [31:0] dst_data;
    logic        dst_ready = 1'b1;
    logic        busy, done, err;

    int vectors = 0;
    int errors  = 0;
    int we_cnt = 0, oe_cnt = 0, done_cnt = 0;
    int job_id = 0;

    logic [31:0] exp_bus[$];
    logic [31:0] exp_dst[$];

    // NPU result memory, read sequentially by npu_oe.
    logic [31:0] npu_out [256];
    logic [7:0]  npu_idx = '0;
    assign npu_data_in = npu_out[npu_idx];
    always @(posedge clk) if (npu_oe) npu_idx <= npu_idx + 8'd1;

    always #5 clk = ~clk;

    npu_host_driver #(.READY_TIMEOUT(16'd10)) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .npu_we(npu_we), .npu_data_out(npu_data_out), .npu_data_oe(npu_data_oe),
        .npu_data_in(npu_data_in), .npu_oe(npu_oe), .npu_ready(npu_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready),
        .busy(busy), .done(done), .err(err)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Cycle compare against the scoreboards.
    always @(negedge clk) begin
        if (!rst) begin
            check("data_oe_eq_we", 32'(npu_data_oe), 32'(npu_we));
            if (npu_we) begin
                we_cnt++;
                if (exp_bus.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL bus_extra: unexpected npu_we, data %h at %0t", npu_data_out, $time);
                end else begin
                    check("bus_word", npu_data_out, exp_bus.pop_front());
                end
            end
            if (npu_oe) begin
                oe_cnt++;
                check("oe_needs_ready", 32'(npu_ready), 32'd1);
                check("oe_no_overwrite", 32'(!dst_valid || dst_ready), 32'd1);
            end
            if (dst_valid && dst_ready) begin
                if (exp_dst.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL dst_extra: unexpected word %h at %0t", dst_data, $time);
                end else begin
                    check("dst_word", dst_data, exp_dst.pop_front());
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int t;
        src_valid = 1'b1;
        src_data  = w;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (src_ready) break;
        end
        if (t == 100) begin
            vectors++;
            errors++;
            $display("FAIL send_stall: word %h not consumed", w);
        end
        step();
        src_valid = 1'b0;
    endtask

    // Bus words the header alone produces.
    task automatic push_cfg(input logic [31:0] hdr);
        exp_bus.push_back({30'b0, hdr[1:0]});
        exp_bus.push_back({27'b0, hdr[6:2]});
        exp_bus.push_back({27'b0, hdr[11:7]});
        exp_bus.push_back({27'b0, hdr[16:12]});
        exp_bus.push_back({27'b0, hdr[21:17]});
    endtask

    // Payload length from the layer chain: each neuron = fan-in count + bias.
    function automatic int payload_words(input logic [31:0] hdr);
        int sizes[$];
        int total;
        int nl;
        nl = int'(hdr[1:0]);
        total = 0;
        sizes.push_back(int'(hdr[6:2]) + 1);
        if (nl >= 1) sizes.push_back(int'(hdr[11:7]) + 1);
        if (nl == 2) sizes.push_back(int'(hdr[16:12]) + 1);
        sizes.push_back(int'(hdr[21:17]) + 1);
        for (int i = 0; i + 1 < sizes.size(); i++)
            total += (sizes[i] + 1) * sizes[i + 1];
        return total + int'(hdr[6:2]) + 1;
    endfunction

    // Sends the header and up to stop_after payload words (<0: all).
    task automatic stream_job(input logic [31:0] hdr, input int stop_after);
        int n;
        logic [31:0] w;
        job_id++;
        n = payload_words(hdr);
        if (stop_after >= 0 && stop_after < n) n = stop_after;
        push_cfg(hdr);
        send(hdr);
        check("hdr_err_clear", 32'(err), 32'd0);
        check("hdr_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            w = 32'hA000_0000 + 32'(job_id) * 32'h100 + 32'(i);
            exp_bus.push_back(w);
            send(w);
        end
    endtask

    task automatic run_job(input logic [31:0] hdr, input bit toggle,
                           input int exp_we, input string tag);
        int base_we, base_oe, base_done, nout, c;
        base_we   = we_cnt;
        base_oe   = oe_cnt;
        base_done = done_cnt;
        stream_job(hdr, -1);
        check({tag, "_wait_src_ready"}, 32'(src_ready), 32'd0);
        check({tag, "_no_err"}, 32'(err), 32'd0);
        nout = int'(hdr[21:17]) + 1;
        for (int i = 0; i < nout; i++) begin
            npu_out[npu_idx + 8'(i)] = 32'hD000_0000 + 32'(job_id) * 32'h100 + 32'(i);
            exp_dst.push_back(32'hD000_0000 + 32'(job_id) * 32'h100 + 32'(i));
        end
        npu_ready = 1'b1;
        for (c = 0; c < 400; c++) begin
            dst_ready = toggle ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
            @(negedge clk);
            if (done) break;
            step();
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_dst_drained"}, 32'(exp_dst.size()), 32'd0);
        check({tag, "_dst_valid_low"}, 32'(dst_valid), 32'd0);
        check({tag, "_we_count"}, 32'(we_cnt - base_we), 32'(exp_we));
        check({tag, "_oe_count"}, 32'(oe_cnt - base_oe), 32'(nout));
        step();
        npu_ready = 1'b0;
        dst_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done_cnt - base_done), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_bus_drained"}, 32'(exp_bus.size()), 32'd0);
        step();
    endtask

    initial begin
        int n, base_oe;
        // Reset state
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_npu_we", 32'(npu_we), 32'd0);
        check("rst_data_oe", 32'(npu_data_oe), 32'd0);
        check("rst_npu_oe", 32'(npu_oe), 32'd0);
        check("rst_data_out", npu_data_out, 32'd0);
        check("rst_dst_valid", 32'(dst_valid), 32'd0);
        check("rst_dst_data", dst_data, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_src_ready", 32'(src_ready), 32'd1);
        step();

        // 0 hidden, n0=1, n3=0: 5 cfg + 3 load + 2 input
        run_job(32'h0000_0004, 1'b0, 10, "job_zero_hidden");
        // 2 hidden, all fields 1: 5 cfg + 18 load + 2 input
        run_job(32'h0002_1086, 1'b0, 25, "job_two_hidden");
        // n3=3, dst_ready toggling 1,0,0,1: 5 cfg + 8 load + 1 input
        run_job(32'h0006_0000, 1'b1, 14, "job_backpressure");

        // Underrun mid-LOAD (1 hidden, n0=2, n1=1, n3=0; 11 load words)
        stream_job(32'h0000_0089, 4);
        @(negedge clk);
        check("underrun_err_pending", 32'(err), 32'd0);
        step();
        check("underrun_err", 32'(err), 32'd1);
        check("underrun_busy", 32'(busy), 32'd0);
        repeat (3) step();
        check("underrun_bus_drained", 32'(exp_bus.size()), 32'd0);

        // Timeout: npu_ready never rises (2 load words, 1 input word)
        base_oe = oe_cnt;
        stream_job(32'h0000_0000, -1);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check("timeout_wait_cycles", 32'(n), 32'd10);
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_no_oe", 32'(oe_cnt - base_oe), 32'd0);
        check("timeout_bus_drained", 32'(exp_bus.size()), 32'd0);

        // Reset in the middle of CFG
        push_cfg(32'h0002_1086);
        send(32'h0002_1086);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_bus.delete();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_src_ready", 32'(src_ready), 32'd1);
        repeat (2) step();

        // Bad header: consumed, err set, no bus activity
        send(32'h0000_0003);
        check("badhdr_err", 32'(err), 32'd1);
        check("badhdr_busy", 32'(busy), 32'd0);
        check("badhdr_src_ready", 32'(src_ready), 32'd1);
        repeat (2) step();
        run_job(32'h0000_0004, 1'b0, 10, "job_after_bad");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
